// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter_pkg
//  Brief    : Shared CDB widths, tag codes and requester indices.
//  Revision : 1.0
// ============================================================================
package cdb_arbiter_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 64;

    typedef enum logic [3:0] {
        NOTAG  = 4'd0,
        ADD_1  = 4'd1,
        ADD_2  = 4'd2,
        ADD_3  = 4'd3,
        MULT_1 = 4'd4,
        MULT_2 = 4'd5,
        LD_1   = 4'd6,
        LD_2   = 4'd7,
        LD_3   = 4'd8,
        ST_1   = 4'd9,
        ST_2   = 4'd10
    } tag_e;

    localparam int REQ_ADD  = 0;
    localparam int REQ_MULT = 1;
    localparam int REQ_LD   = 2;

    // Index after idx in a ring of n entries.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter_if
//  Brief    : Requester handshake and CDB broadcast bundle.
//  Revision : 1.0
// ============================================================================
interface cdb_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int TAG_W  = cdb_arbiter_pkg::TAG_W,
    parameter int DATA_W = cdb_arbiter_pkg::DATA_W
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*TAG_W-1:0]  req_tag;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;

    modport master (
        output req_valid, req_tag, req_data,
        input  req_ready, cdb_valid, cdb_tag, cdb_data
    );

    modport slave (
        input  req_valid, req_tag, req_data,
        output req_ready, cdb_valid, cdb_tag, cdb_data
    );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter_rr_grant.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter_rr_grant
//  Brief    : Combinational rotating-priority one-hot grant with granted index.
//  Revision : 1.0
// ============================================================================
module cdb_arbiter_rr_grant #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [PTR_W-1:0] i_ptr,
    output logic      [N_REQ-1:0] o_grant,
    output logic      [PTR_W-1:0] o_idx,
    output logic                  o_any
);
    int w_pos;

    // Walk upward from the pointer; the first valid requester wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = 0;
        for (int off = 0; off < N_REQ; off++) begin
            w_pos = (int'(i_ptr) + off) % N_REQ;
            if (!o_any && i_req[w_pos]) begin
                o_grant[w_pos] = 1'b1;
                o_idx          = PTR_W'(w_pos);
                o_any          = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Brief    : Round-robin CDB arbiter with a registered one-cycle broadcast.
//  Revision : 1.0
// ============================================================================
module cdb_arbiter #(
    parameter int N_REQ  = 3,
    parameter int TAG_W  = cdb_arbiter_pkg::TAG_W,
    parameter int DATA_W = cdb_arbiter_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       flush,
    cdb_arbiter_if.slave    bus,
    output logic            tag_err,
    output logic [CNT_W-1:0] bcast_cnt
);
    import cdb_arbiter_pkg::*;

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  w_req;
    logic [N_REQ-1:0]  w_grant;
    logic [PTR_W-1:0]  w_idx;
    logic              w_any;
    logic [TAG_W-1:0]  w_tag;
    logic [DATA_W-1:0] w_data;
    logic              w_notag;
    logic              w_bcast;

    logic [PTR_W-1:0]  r_rr_ptr;
    logic              r_cdb_valid;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_data;
    logic              r_tag_err;
    logic [CNT_W-1:0]  r_bcast_cnt;

    // Masking requests with flush suppresses the grant and keeps rr_ptr still.
    assign w_req = bus.req_valid & {N_REQ{~flush}};

    cdb_arbiter_rr_grant #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_grant (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_tag   = bus.req_tag[w_idx*TAG_W +: TAG_W];
    assign w_data  = bus.req_data[w_idx*DATA_W +: DATA_W];
    assign w_notag = (w_tag == TAG_W'(NOTAG));
    assign w_bcast = w_any & ~w_notag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_tag_err   <= 1'b0;
            r_bcast_cnt <= '0;
        end else begin
            r_cdb_valid <= w_bcast;
            r_cdb_tag   <= w_bcast ? w_tag  : '0;
            r_cdb_data  <= w_bcast ? w_data : '0;
            if (w_any) begin
                r_rr_ptr <= PTR_W'(next_idx(int'(w_idx), N_REQ));
                if (w_notag) begin
                    r_tag_err <= 1'b1;
                end
            end
            if (w_bcast) begin
                r_bcast_cnt <= r_bcast_cnt + 1'b1;
            end
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.cdb_valid = r_cdb_valid;
    assign bus.cdb_tag   = r_cdb_tag;
    assign bus.cdb_data  = r_cdb_data;
    assign tag_err       = r_tag_err;
    assign bcast_cnt     = r_bcast_cnt;
endmodule
`default_nettype wire
